// File: rtl/pwl_act_pkg.sv
// Shared constants for the piecewise-linear sigmoid/tanh unit, defined at a 11-bit reference
// fraction and rescaled to the instance FRAC with rescale().
package pwl_act_pkg;

  localparam int     FRAC_REF = 11;
  localparam longint ONE      = longint'(1) <<< FRAC_REF;

  localparam longint BP_N6 = -6 * ONE;
  localparam longint BP_N4 = -4 * ONE;
  localparam longint BP_N2 = -2 * ONE;
  localparam longint BP_P2 =  2 * ONE;
  localparam longint BP_P4 =  4 * ONE;
  localparam longint BP_P6 =  6 * ONE;

  localparam longint M_OUTER = 60;
  localparam longint M_MID   = 250;
  localparam longint M_INNER = 390;

  localparam longint C_SEG1 = 286;
  localparam longint C_SEG2 = 584;
  localparam longint C_SEG3 = 1024;
  localparam longint C_SEG4 = 1464;
  localparam longint C_SEG5 = 1762;

  localparam longint SAT_LOW  = 5;
  localparam longint SAT_HIGH = 2043;

  localparam logic MODE_SIG  = 1'b0;
  localparam logic MODE_TANH = 1'b1;

  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_LO   = 2'd1,
    SAT_HI   = 2'd2
  } sat_e;

  function automatic longint rescale(input longint v, input int frac);
    if (frac >= FRAC_REF) return v <<< (frac - FRAC_REF);
    return v >>> (FRAC_REF - frac);
  endfunction

endpackage

// File: rtl/pwl_lane.sv
// One lane of the PWL activation datapath: S1 prescale+decode, S2 multiply-add, S3 saturate/tanh.
// Build option PWL_ROUND_EN selects round-half-up in S2 instead of arithmetic-shift truncation.
module pwl_lane
  import pwl_act_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic                mode_s1_i,
  input  logic                mode_s3_i,
  input  logic signed [W-1:0] x_i,
  output logic signed [W-1:0] y_o
);

  localparam logic signed [W-1:0] ONE_L      = W'(rescale(ONE, FRAC));
  localparam logic signed [W-1:0] BP_N6_L    = W'(rescale(BP_N6, FRAC));
  localparam logic signed [W-1:0] BP_N4_L    = W'(rescale(BP_N4, FRAC));
  localparam logic signed [W-1:0] BP_N2_L    = W'(rescale(BP_N2, FRAC));
  localparam logic signed [W-1:0] BP_P2_L    = W'(rescale(BP_P2, FRAC));
  localparam logic signed [W-1:0] BP_P4_L    = W'(rescale(BP_P4, FRAC));
  localparam logic signed [W-1:0] BP_P6_L    = W'(rescale(BP_P6, FRAC));
  localparam logic signed [W-1:0] M_OUTER_L  = W'(rescale(M_OUTER, FRAC));
  localparam logic signed [W-1:0] M_MID_L    = W'(rescale(M_MID, FRAC));
  localparam logic signed [W-1:0] M_INNER_L  = W'(rescale(M_INNER, FRAC));
  localparam logic signed [W-1:0] C_SEG1_L   = W'(rescale(C_SEG1, FRAC));
  localparam logic signed [W-1:0] C_SEG2_L   = W'(rescale(C_SEG2, FRAC));
  localparam logic signed [W-1:0] C_SEG3_L   = W'(rescale(C_SEG3, FRAC));
  localparam logic signed [W-1:0] C_SEG4_L   = W'(rescale(C_SEG4, FRAC));
  localparam logic signed [W-1:0] C_SEG5_L   = W'(rescale(C_SEG5, FRAC));
  localparam logic signed [W-1:0] SAT_LOW_L  = W'(rescale(SAT_LOW, FRAC));
  localparam logic signed [W-1:0] SAT_HIGH_L = W'(rescale(SAT_HIGH, FRAC));
`ifdef PWL_ROUND_EN
  localparam logic signed [2*W-1:0] RND_L = (2*W)'(longint'(1) <<< (FRAC - 1));
`endif

  // 2*x clamped to the W-bit signed range (overflow shows as MSB/next-bit disagreement)
  function automatic logic signed [W-1:0] sat_dbl(input logic signed [W-1:0] x);
    logic signed [W:0] d;
    d = {x, 1'b0};
    if (d[W] != d[W-1]) return d[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return d[W-1:0];
  endfunction

  function automatic logic signed [2*W-1:0] shr_frac(input logic signed [2*W-1:0] p);
`ifdef PWL_ROUND_EN
    return (p + RND_L) >>> FRAC;
`else
    return p >>> FRAC;
`endif
  endfunction

  logic signed [W-1:0] xs_d, m_d, c_d;
  sat_e                sat_d;
  logic signed [W-1:0] xs_p1_q, m_p1_q, c_p1_q;
  sat_e                sat_p1_q;

  always_comb begin
    xs_d  = (mode_s1_i == MODE_TANH) ? sat_dbl(x_i) : x_i;
    sat_d = SAT_NONE;
    m_d   = M_INNER_L;
    c_d   = C_SEG3_L;
    if (xs_d < BP_N6_L)      sat_d = SAT_LO;
    else if (xs_d > BP_P6_L) sat_d = SAT_HI;
    if (xs_d < BP_N4_L) begin
      m_d = M_OUTER_L;
      c_d = C_SEG1_L;
    end else if (xs_d < BP_N2_L) begin
      m_d = M_MID_L;
      c_d = C_SEG2_L;
    end else if (xs_d < BP_P2_L) begin
      m_d = M_INNER_L;
      c_d = C_SEG3_L;
    end else if (xs_d < BP_P4_L) begin
      m_d = M_MID_L;
      c_d = C_SEG4_L;
    end else begin
      m_d = M_OUTER_L;
      c_d = C_SEG5_L;
    end
  end

  // ---- S1 -> S2 boundary ----
  logic signed [2*W-1:0] m_ext, xs_ext, prod, shr;
  logic signed [W-1:0]   s_d;
  logic signed [W-1:0]   s_p2_q;
  sat_e                  sat_p2_q;

  assign m_ext  = $signed({{W{m_p1_q[W-1]}}, m_p1_q});
  assign xs_ext = $signed({{W{xs_p1_q[W-1]}}, xs_p1_q});
  assign prod   = m_ext * xs_ext;
  assign shr    = shr_frac(prod);
  assign s_d    = $signed(shr[W-1:0]) + c_p1_q;

  // ---- S2 -> S3 boundary ----
  logic signed [W-1:0] sv, y_d, y_q;

  always_comb begin
    sv = s_p2_q;
    if (sat_p2_q == SAT_LO)      sv = SAT_LOW_L;
    else if (sat_p2_q == SAT_HI) sv = SAT_HIGH_L;
    y_d = (mode_s3_i == MODE_TANH) ? (sv <<< 1) - ONE_L : sv;
  end

  // Datapath registers carry no reset: their contents only matter under a valid bit.
  always_ff @(posedge clk) begin
    if (en_i) begin
      xs_p1_q  <= xs_d;
      m_p1_q   <= m_d;
      c_p1_q   <= c_d;
      sat_p1_q <= sat_d;
      s_p2_q   <= s_d;
      sat_p2_q <= sat_p1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    y_q <= '0;
    else if (en_i) y_q <= y_d;
  end

  assign y_o = y_q;

endmodule

// File: rtl/pwl_act_simd.sv
// N-lane piecewise-linear sigmoid/tanh unit with valid/ready backpressure; 3-stage pipe.
// Build option PWL_ROUND_EN enables round-half-up in the multiply-add stage.
module pwl_act_simd
  import pwl_act_pkg::*;
#(
  parameter int LANES = 4,
  parameter int W     = 16,
  parameter int FRAC  = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [LANES*W-1:0]   x_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_mode,
  output logic [LANES*W-1:0]   y_out
);

  logic adv;
  logic vld_p1_q, vld_p2_q, vld_p3_q;
  logic mode_p1_q, mode_p2_q, mode_p3_q;

  // Single global enable: the whole pipe freezes while the output beat is held.
  assign adv      = !vld_p3_q || out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      vld_p3_q  <= 1'b0;
      mode_p1_q <= MODE_SIG;
      mode_p2_q <= MODE_SIG;
      mode_p3_q <= MODE_SIG;
    end else if (adv) begin
      vld_p1_q  <= in_valid;
      vld_p2_q  <= vld_p1_q;
      vld_p3_q  <= vld_p2_q;
      mode_p1_q <= in_mode;
      mode_p2_q <= mode_p1_q;
      mode_p3_q <= mode_p2_q;
    end
  end

  assign out_valid = vld_p3_q;
  assign out_mode  = mode_p3_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pwl_lane #(
      .W    (W),
      .FRAC (FRAC)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (adv),
      .mode_s1_i (in_mode),
      .mode_s3_i (mode_p2_q),
      .x_i       (x_in[i*W +: W]),
      .y_o       (y_out[i*W +: W])
    );
  end

endmodule

// File: tb/tb_pwl_act_simd.sv
// Bench for pwl_act_simd (LANES=4, W=16, FRAC=11): behavioural model + scoreboard checked every cycle.
module tb_pwl_act_simd;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic [63:0] x_in;
  logic        out_valid;
  logic        out_ready;
  logic        out_mode;
  logic [63:0] y_out;

  pwl_act_simd #(.LANES(4), .W(16), .FRAC(11)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mode  (out_mode),
    .y_out     (y_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Sigmoid/tanh as piecewise-linear curve in real units (1.0 = 2048), floor division spelled out.
  function automatic longint model(input longint x, input logic mode);
    longint xs, m, c, p, sv;
    xs = mode ? 2 * x : x;
    if (xs > 32767)  xs = 32767;
    if (xs < -32768) xs = -32768;
    m = 0;
    c = 0;
    if (xs < -6 * 2048)      sv = 5;
    else if (xs > 6 * 2048)  sv = 2043;
    else begin
      if (xs < -4 * 2048)      begin m = 60;  c = 286;  end
      else if (xs < -2 * 2048) begin m = 250; c = 584;  end
      else if (xs <  2 * 2048) begin m = 390; c = 1024; end
      else if (xs <  4 * 2048) begin m = 250; c = 1464; end
      else                     begin m = 60;  c = 1762; end
      p = m * xs;
`ifdef PWL_ROUND_EN
      p = p + 1024;
`endif
      sv = (p - (((p % 2048) + 2048) % 2048)) / 2048 + c;
    end
    if (mode) return 2 * sv - 2048;
    return sv;
  endfunction

  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  typedef struct {
    logic [63:0] y;
    logic        m;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] stim_x[32];
  logic        stim_m[32];
  bit          saw_backp;

  // Compare process: scoreboard, handshake rule and stall stability, sampled on the falling edge.
  initial begin
    bit          stall_prev;
    logic [63:0] y_prev;
    logic        m_prev;
    beat_t       e;
    longint      v;
    stall_prev = 1'b0;
    y_prev     = '0;
    m_prev     = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        stall_prev = 1'b0;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_mode", longint'(out_mode), 0);
        chk("rst_y_out", longint'(y_out), 0);
      end else begin
        chk("in_ready_rule", longint'(in_ready), longint'(!out_valid || out_ready));
        if (stall_prev) begin
          chk("stall_y_hold", longint'(y_out), longint'(y_prev));
          chk("stall_mode_hold", longint'(out_mode), longint'(m_prev));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            for (int i = 0; i < 4; i++)
              chk($sformatf("y_lane%0d", i), longint'($signed(y_out[i*16 +: 16])),
                  longint'($signed(e.y[i*16 +: 16])));
            chk("out_mode", longint'(out_mode), longint'(e.m));
          end
        end
        if (in_valid && in_ready) begin
          e.m = in_mode;
          for (int i = 0; i < 4; i++) begin
            v = model(longint'($signed(x_in[i*16 +: 16])), in_mode);
            e.y[i*16 +: 16] = v[15:0];
          end
          exp_q.push_back(e);
        end
        stall_prev = out_valid && !out_ready;
        y_prev     = y_out;
        m_prev     = out_mode;
      end
    end
  end

  // Feed beats [first, first+n); stall out_ready for a window; optionally pulse reset at cycle rst_at.
  task automatic stream(input int first, input int n, input int stall_at, input int stall_len,
                        input int rst_at, input bit dense);
    int idx, cyc, outs, first_out, last_out;
    bit acc;
    idx = first; cyc = 0; outs = 0; first_out = -1; last_out = -1;
    while (cyc < 200 && (idx < first + n || exp_q.size() > 0 || out_valid)) begin
      if (cyc == rst_at) begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        break;
      end
      in_valid = (idx < first + n);
      if (in_valid) begin
        x_in    = stim_x[idx];
        in_mode = stim_m[idx];
      end
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        outs++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      if (out_valid && !out_ready && !in_ready) saw_backp = 1'b1;
      @(posedge clk);
      #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (rst_at < 0) chk("stream_timeout", longint'(cyc < 200), 1);
    if (dense) begin
      chk("dense_count", outs, n);
      chk("dense_no_bubble", last_out - first_out + 1, n);
    end
  endtask

  initial begin
    // Model pinned to hand-computed points (x=+6.0: 60*6+1762 = 2122, in range, not SAT_HIGH).
    chk("pin_sig_0", model(0, 0), 1024);
    chk("pin_sig_p7", model(14336, 0), 2043);
    chk("pin_sig_n7", model(-14336, 0), 5);
    chk("pin_sig_p2", model(4096, 0), 1964);
    chk("pin_sig_p6", model(12288, 0), 2122);
    chk("pin_tanh_0", model(0, 1), 0);
    chk("pin_tanh_p1", model(2048, 1), 1880);
    chk("pin_tanh_p8", model(16384, 1), 2038);
    chk("pin_tanh_n8", model(-16384, 1), -2038);
`ifdef PWL_ROUND_EN
    chk("pin_sig_m1lsb", model(-1, 0), 1024);
`else
    chk("pin_sig_m1lsb", model(-1, 0), 1023);
`endif

    stim_x[0]  = pk(0, 14336, -14336, 4096);        stim_m[0]  = 1'b0;
    stim_x[1]  = pk(12288, -1, -12288, -8192);      stim_m[1]  = 1'b0;
    stim_x[2]  = pk(0, 2048, 16384, -16384);        stim_m[2]  = 1'b1;
    stim_x[3]  = pk(-1, 6144, -2048, 16383);        stim_m[3]  = 1'b1;
    stim_x[4]  = pk(-4096, -2048, 2048, 8191);      stim_m[4]  = 1'b0;
    stim_x[5]  = pk(-6144, 6145, -6145, 4095);      stim_m[5]  = 1'b1;
    for (int k = 6; k < 32; k++) begin
      stim_x[k] = pk(k * 731 - 9000, 12000 - k * 977, (k * 1301) % 30000 - 15000, k * 113);
      stim_m[k] = k[0];
    end

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    x_in      = '0;
    out_ready = 1'b1;
    saw_backp = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", longint'(in_ready), 1);
    chk("post_rst_out_valid", longint'(out_valid), 0);
    @(posedge clk);
    #1;

    stream(0, 6, -1, 0, -1, 1'b0);
    stream(6, 5, 3, 4, -1, 1'b0);
    chk("backpressure_seen", longint'(saw_backp), 1);
    stream(11, 8, -1, 0, -1, 1'b1);
    stream(19, 8, -1, 0, 5, 1'b0);
    repeat (8) begin
      @(negedge clk);
      chk("post_reset_no_stale", longint'(out_valid), 0);
    end
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
